// File: rtl/subtrator_serial4b_if.sv
// ----------------------------------------------------------------------------
// subtrator_serial4b_if
// Bundles the start/ready request and the result/done return path of the
// bit-serial subtractor.
//   start, a, b, bin  : request side (driven by the master)
//   ready, busy       : status (driven by the slave)
//   d, bout, done     : result side (driven by the slave)
//   ovf               : signed overflow, present only with SUBTRATOR_OVERFLOW_EN
// Build option: define SUBTRATOR_OVERFLOW_EN to add the ovf signal.
// ----------------------------------------------------------------------------
interface subtrator_serial4b_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             done;
`ifdef SUBTRATOR_OVERFLOW_EN
  logic             ovf;

  modport master (output start, a, b, bin, input ready, busy, d, bout, done, ovf);
  modport slave  (input start, a, b, bin, output ready, busy, d, bout, done, ovf);
`else
  modport master (output start, a, b, bin, input ready, busy, d, bout, done);
  modport slave  (input start, a, b, bin, output ready, busy, d, bout, done);
`endif
endinterface

// File: rtl/subtrator_serial4b.sv
// ----------------------------------------------------------------------------
// subtrator_serial4b
// Bit-serial subtractor: D = A - B - bin (mod 2^WIDTH), one full-subtractor
// cell iterated LSB-first, one bit per clock.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : subtrator_serial4b_if.slave
//            start/a/b/bin in; ready/busy/d/bout/done out (+ ovf, optional)
// Timing: accepting edge E0, bits processed on E1..E_WIDTH, done high for
// the single cycle following E_WIDTH. d/bout only change on DONE entry.
// Build option: SUBTRATOR_OVERFLOW_EN adds a registered signed-overflow flag.
// ----------------------------------------------------------------------------
module subtrator_serial4b #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  subtrator_serial4b_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bout_q, bout_d;
`ifdef SUBTRATOR_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic             a_bit, b_bit;
  logic             diff_bit, borrow_bit;
  logic [WIDTH-1:0] res_full;

  // Full-subtractor cell on the current bit position.
  assign a_bit      = ra_q[cnt_q];
  assign b_bit      = rb_q[cnt_q];
  assign diff_bit   = a_bit ^ b_bit ^ br_q;
  assign borrow_bit = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

  always_comb begin
    res_full        = res_q;
    res_full[cnt_q] = diff_bit;
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dout_d  = dout_q;
    bout_d  = bout_q;
`ifdef SUBTRATOR_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      SHIFT: begin
        res_d = res_full;
        br_d  = borrow_bit;
        if (cnt_q == CNT_LAST) begin
          // Publish the whole word at once so d never shows partial results.
          state_d = DONE;
          dout_d  = res_full;
          bout_d  = borrow_bit;
`ifdef SUBTRATOR_OVERFLOW_EN
          ovf_d   = (ra_q[WIDTH-1] ^ rb_q[WIDTH-1]) & (res_full[WIDTH-1] ^ ra_q[WIDTH-1]);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE otherwise falls to IDLE.
        state_d = IDLE;
        if (bus.start) begin
          state_d = SHIFT;
          ra_d    = bus.a;
          rb_d    = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      dout_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SUBTRATOR_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      bout_q  <= bout_d;
`ifdef SUBTRATOR_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.ready = (state_q != SHIFT);
  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = (state_q == DONE);
  assign bus.d     = dout_q;
  assign bus.bout  = bout_q;
`ifdef SUBTRATOR_OVERFLOW_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_subtrator_serial4b.sv
// ----------------------------------------------------------------------------
// tb_subtrator_serial4b
// Directed and randomized operations on subtrator_serial4b, compared with an
// arithmetic reference model (integer subtraction, unsigned compare, signed
// range check for overflow).
// Build option: SUBTRATOR_OVERFLOW_EN also exercises the ovf output.
// ----------------------------------------------------------------------------
module tb_subtrator_serial4b;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   cycles;
  int   last_done_cycle;
  bit   prev_hold;
  logic [W-1:0] last_d;
  logic         last_bout;
  logic         last_ovf;

  subtrator_serial4b_if #(.WIDTH(W)) bus ();

  subtrator_serial4b #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycles <= cycles + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: drive at a negedge, accept on the next edge, then watch
  // WIDTH+1 negedges. Returns at the negedge inside the DONE cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit hold, input bit noise);
    int           diff;
    int           sdiff;
    logic [W-1:0] exp_d;
    logic         exp_b;
    logic         exp_o;
    bit           chained;
    diff    = int'(a) - int'(b) - int'(bin);
    exp_d   = W'(diff);
    exp_b   = (int'(a) < int'(b) + int'(bin));
    sdiff   = int'($signed(a)) - int'($signed(b)) - int'(bin);
    exp_o   = (sdiff < -(2 ** (W - 1))) || (sdiff > (2 ** (W - 1)) - 1);
    chained = prev_hold;

    check("ready_before_start", bus.ready, 1);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    // Operands may change freely once latched.
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.bin = 1'($urandom);

    for (int cyc = 0; cyc <= W; cyc++) begin
      @(negedge clk);
      check("done", bus.done, (cyc == W));
      check("busy", bus.busy, (cyc < W));
      check("ready", bus.ready, (cyc == W));
      if (cyc == W) begin
        check("d", bus.d, exp_d);
        check("bout", bus.bout, exp_b);
`ifdef SUBTRATOR_OVERFLOW_EN
        check("ovf", bus.ovf, exp_o);
`endif
        if (chained) check("done_spacing", cycles - last_done_cycle, W + 1);
        last_done_cycle = cycles;
      end else begin
        check("d_hold", bus.d, last_d);
        check("bout_hold", bus.bout, last_bout);
`ifdef SUBTRATOR_OVERFLOW_EN
        check("ovf_hold", bus.ovf, last_ovf);
`endif
      end
      if (noise && cyc == 1) begin
        bus.start = 1'b1;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom);
      end
      if (noise && cyc == 2 && !hold) bus.start = 1'b0;
    end
    last_d    = exp_d;
    last_bout = exp_b;
    last_ovf  = exp_o;
    prev_hold = hold;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cycles = 0; last_done_cycle = 0;
    prev_hold = 0; last_d = '0; last_bout = 1'b0; last_ovf = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_d", bus.d, 0);
    check("rst_bout", bus.bout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed basics.
    run_op(4'd5, 4'd3, 1'b0, 0, 0);
    run_op(4'd3, 4'd5, 1'b0, 0, 0);
    run_op(4'd0, 4'd0, 1'b1, 0, 0);

    // start held high: back-to-back results.
    run_op(4'd9, 4'd4, 1'b0, 1, 0);
    run_op(4'd7, 4'd7, 1'b0, 1, 0);
    bus.start = 1'b0;
    prev_hold = 0;
    @(negedge clk);
    check("idle_ready", bus.ready, 1);
    check("idle_done", bus.done, 0);

    // start pulsed during SHIFT is ignored.
    run_op(4'd12, 4'd5, 1'b0, 0, 1);
    @(negedge clk);

    // Reset in the middle of SHIFT after two bits.
    bus.start = 1'b1; bus.a = 4'd3; bus.b = 4'd5; bus.bin = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", bus.ready, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_d", bus.d, 0);
    check("midrst_bout", bus.bout, 0);
    last_d = '0; last_bout = 1'b0; last_ovf = 1'b0; prev_hold = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", bus.done, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("post_rst_no_done", bus.done, 0);
    end
    run_op(4'd10, 4'd6, 1'b1, 0, 0);

`ifdef SUBTRATOR_OVERFLOW_EN
    run_op(4'd8, 4'd1, 1'b0, 0, 0);
    run_op(4'd7, 4'd1, 1'b0, 0, 0);
    run_op(4'd0, 4'd8, 1'b0, 0, 0);
`endif

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)));
    end
    bus.start = 1'b0;
    prev_hold = 0;
    @(negedge clk);
    check("final_idle_ready", bus.ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
